// File: rtl/vram_arbiter_pkg.sv
// asip_arb_pkg: shared types and default sizes for the VRAM arbiter.
//   arb_state_e : arbiter FSM states
//   grant_e     : which requester owns the RAM (also the last_grant record)
`timescale 1ns/1ps
package asip_arb_pkg;
  localparam int V_DEF            = 192;
  localparam int ADDR_W_DEF       = 16;
  localparam int CPU_MAX_WAIT_DEF = 8;

  typedef enum logic [1:0] {IDLE, CPU_ACC, VGA_ACC} arb_state_e;
  typedef enum logic {GRANT_CPU, GRANT_VGA} grant_e;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles the CPU (MEM stage), VGA fetch and RAM macro
// signals around the arbiter.
//   slave  : arbiter view (requests/mem_rdata in, acks/rdata/mem_* out)
//   master : requester + RAM view (the opposite directions)
`timescale 1ns/1ps
interface vram_arbiter_if
  import asip_arb_pkg::*;
#(
  parameter int V      = V_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [V-1:0]      cpu_wdata;
  logic [V-1:0]      cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;
  logic              vga_req;
  logic              vga_urgent;
  logic [ADDR_W-1:0] vga_addr;
  logic [V-1:0]      vga_rdata;
  logic              vga_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [V-1:0]      mem_wdata;
  logic [V-1:0]      mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  vga_req, vga_urgent, vga_addr,
    output vga_rdata, vga_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output vga_req, vga_urgent, vga_addr,
    input  vga_rdata, vga_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vram_arbiter_wait_counter.sv
// arb_wait_counter: saturating count of IDLE cycles the CPU lost arbitration.
//   clk, rst : clock, async active-low reset
//   inc      : count one lost cycle (holds once saturated)
//   clr      : return to zero (wins over inc)
//   sat      : count has reached MAX
`timescale 1ns/1ps
module arb_wait_counter #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else if (clr)
      cnt_q <= '0;
    else if (inc && !sat)
      cnt_q <= cnt_q + 1'b1;
  end

  assign sat = (cnt_q == W'(MAX));
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port data RAM between the CPU MEM stage
// and the VGA scanout fetcher, one access per two cycles.
//   clk, rst : system clock, async active-low reset
//   bus      : vram_arbiter_if.slave (CPU, VGA and RAM signals)
//
// state   | meaning
// IDLE    | arbitrate; winner's request is issued to the RAM this cycle
// CPU_ACC | RAM data for the CPU is valid; cpu_ack pulses
// VGA_ACC | RAM data for the VGA is valid; vga_ack pulses
`timescale 1ns/1ps
module vram_arbiter
  import asip_arb_pkg::*;
#(
  parameter int CPU_MAX_WAIT = CPU_MAX_WAIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  vram_arbiter_if.slave bus
);
  arb_state_e state_q, state_d;
  grant_e     last_grant_q, last_grant_d;
  logic       grant_cpu, grant_vga;
  logic       wait_sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_VGA;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    grant_cpu = 1'b0;
    grant_vga = 1'b0;
    if (state_q == IDLE) begin
      if (bus.cpu_req && !bus.vga_req)
        grant_cpu = 1'b1;
      else if (!bus.cpu_req && bus.vga_req)
        grant_vga = 1'b1;
      else if (bus.cpu_req && bus.vga_req) begin
        if (wait_sat)
          grant_cpu = 1'b1;
        else if (bus.vga_urgent)
          grant_vga = 1'b1;
        else if (last_grant_q == GRANT_VGA)
          grant_cpu = 1'b1;
        else
          grant_vga = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cpu_ack   = 1'b0;
    bus.vga_ack   = 1'b0;
    bus.cpu_rdata = '0;
    bus.vga_rdata = '0;
    case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = bus.cpu_we;
          bus.mem_addr  = bus.cpu_addr;
          bus.mem_wdata = bus.cpu_wdata;
          state_d       = CPU_ACC;
          last_grant_d  = GRANT_CPU;
        end else if (grant_vga) begin
          bus.mem_en    = 1'b1;
          bus.mem_addr  = bus.vga_addr;
          state_d       = VGA_ACC;
          last_grant_d  = GRANT_VGA;
        end
      end
      CPU_ACC: begin
        bus.cpu_ack = 1'b1;
        // cpu_we is still held here, so a write ack returns zero data.
        if (!bus.cpu_we)
          bus.cpu_rdata = bus.mem_rdata;
        state_d = IDLE;
      end
      VGA_ACC: begin
        bus.vga_ack   = 1'b1;
        bus.vga_rdata = bus.mem_rdata;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // IDLE issue is combinational from the requests; keep the RAM quiet
    // while reset is held even if requests are already up.
    if (!rst) begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
    end
  end

  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;

  arb_wait_counter #(.MAX(CPU_MAX_WAIT)) u_wait (
    .clk (clk),
    .rst (rst),
    .inc (grant_vga & bus.cpu_req),
    .clr (grant_cpu | ~bus.cpu_req),
    .sat (wait_sat)
  );
endmodule
